// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline write-enable/flush/bubble sequencing for load-use and branch-in-ID hazards,
// cache freeze handling and a freeze watchdog. Define HAZARD_PERF_EN to add performance counter ports.
module hazard_ctrl #(
   parameter int FREEZE_MAX = 255,
   parameter int PERF_W     = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_use_rs,
   input  logic       ID_use_rt,
   input  logic       ID_branch,
   input  logic       ID_redirect,
   input  logic       EX_MemRead,
   input  logic       EX_RegWrite,
   input  logic [4:0] EX_rd,
   input  logic       MEM_MemRead,
   input  logic [4:0] MEM_rd,
   input  logic       icache_stall,
   input  logic       dcache_stall,
   output logic       PC_write,
   output logic       IF_ID_write,
   output logic       IF_flush,
   output logic       ID_EX_bubble,
   output logic       EX_MEM_write,
   output logic       MEM_WB_write,
   output logic       freeze_err,
   output logic [1:0] hz_state
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] hz_stall_cycles,
   output logic [PERF_W-1:0] frz_cycles,
   output logic [PERF_W-1:0] flush_count
`endif
);

   localparam int FC_W = ($clog2(FREEZE_MAX + 1) > 8) ? $clog2(FREEZE_MAX + 1) : 8;
   localparam logic [FC_W-1:0] FC_MAX = FC_W'(FREEZE_MAX);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_STALL2 = 2'b01,
      ST_FROZEN = 2'b10
   } hz_state_e;

   hz_state_e       state_r, state_nxt_s;
   hz_state_e       ret_r, ret_nxt_s;
   hz_state_e       eff_s, hz_dbg_s;
   logic [1:0]      stall_cnt_r, stall_cnt_nxt_s;
   logic [FC_W-1:0] frz_cnt_r, frz_cnt_nxt_s;
   logic            freeze_err_r;
   logic            m_ex_s, m_mem_s, frz_s, h1_s, h2_s, hazard_s;

   // Register 0 never carries a dependency.
   function automatic logic dep_match(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic use_rs,
                                      input logic use_rt);
      return (rd != 5'd0) && ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));
   endfunction

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

   assign m_ex_s   = dep_match(EX_rd, ID_rs, ID_rt, ID_use_rs, ID_use_rt);
   assign m_mem_s  = dep_match(MEM_rd, ID_rs, ID_rt, ID_use_rs, ID_use_rt);
   assign frz_s    = icache_stall | dcache_stall;
   assign h2_s     = ID_branch & EX_MemRead & m_ex_s;
   assign h1_s     = ~h2_s & ((EX_MemRead & m_ex_s) |
                              (ID_branch & EX_RegWrite & m_ex_s) |
                              (ID_branch & MEM_MemRead & m_mem_s));
   assign hazard_s = (eff_s == ST_STALL2) | ((eff_s == ST_RUN) & (h1_s | h2_s));

   // On the release cycle from FROZEN the controller acts as the saved state.
   always_comb begin
      case (state_r)
         ST_FROZEN:         eff_s = ret_r;
         ST_RUN, ST_STALL2: eff_s = state_r;
         default:           eff_s = ST_RUN;
      endcase
   end

   // Pipeline control outputs, prioritised reset > freeze > stall > run.
   always_comb begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_flush     = 1'b0;
      ID_EX_bubble = 1'b0;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
      hz_dbg_s     = eff_s;
      if (rst) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
         EX_MEM_write = 1'b0;
         MEM_WB_write = 1'b0;
         hz_dbg_s     = ST_RUN;
      end else if (frz_s) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         EX_MEM_write = 1'b0;
         MEM_WB_write = 1'b0;
         hz_dbg_s     = ST_FROZEN;
      end else if (hazard_s) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
      end else begin
         IF_flush     = ID_redirect;
      end
   end

   assign hz_state   = hz_dbg_s;
   assign freeze_err = freeze_err_r;

   // Next-state logic; a freeze parks the FSM and remembers where to resume.
   always_comb begin
      state_nxt_s     = state_r;
      ret_nxt_s       = ret_r;
      stall_cnt_nxt_s = stall_cnt_r;
      if (frz_s) begin
         state_nxt_s = ST_FROZEN;
         if (state_r != ST_FROZEN) begin
            ret_nxt_s = state_r;
         end else begin
            ret_nxt_s = ret_r;
         end
      end else begin
         case (eff_s)
            ST_RUN: begin
               if (h2_s) begin
                  state_nxt_s     = ST_STALL2;
                  stall_cnt_nxt_s = 2'd1;
               end else begin
                  state_nxt_s     = ST_RUN;
               end
            end
            ST_STALL2: begin
               if (stall_cnt_r > 2'd1) begin
                  state_nxt_s     = ST_STALL2;
                  stall_cnt_nxt_s = stall_cnt_r - 2'd1;
               end else begin
                  state_nxt_s     = ST_RUN;
                  stall_cnt_nxt_s = 2'd0;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // FSM state, resume state and stall counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_RUN;
         ret_r       <= ST_RUN;
         stall_cnt_r <= 2'd0;
      end else begin
         state_r     <= state_nxt_s;
         ret_r       <= ret_nxt_s;
         stall_cnt_r <= stall_cnt_nxt_s;
      end
   end

   // Watchdog count of consecutive frozen cycles, saturating at the limit.
   always_comb begin
      if (!frz_s) begin
         frz_cnt_nxt_s = '0;
      end else if (frz_cnt_r >= FC_MAX) begin
         frz_cnt_nxt_s = FC_MAX;
      end else begin
         frz_cnt_nxt_s = frz_cnt_r + FC_W'(1);
      end
   end

   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frz_cnt_r    <= '0;
         freeze_err_r <= 1'b0;
      end else begin
         frz_cnt_r    <= frz_cnt_nxt_s;
         freeze_err_r <= freeze_err_r | (frz_s & (frz_cnt_nxt_s == FC_MAX));
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] hz_stall_cycles_r, frz_cycles_r, flush_count_r;

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hz_stall_cycles_r <= '0;
         frz_cycles_r      <= '0;
         flush_count_r     <= '0;
      end else begin
         if (!frz_s && !PC_write) begin
            hz_stall_cycles_r <= sat_inc(hz_stall_cycles_r);
         end
         if (frz_s) begin
            frz_cycles_r <= sat_inc(frz_cycles_r);
         end
         if (IF_flush) begin
            flush_count_r <= sat_inc(flush_count_r);
         end
      end
   end

   assign hz_stall_cycles = hz_stall_cycles_r;
   assign frz_cycles      = frz_cycles_r;
   assign flush_count     = flush_count_r;
`endif

endmodule
